// File: rtl/xs_video_timing_gen.sv
// Raster timing generator: counters, blanking, sync, flip-adjusted positions and
// sticky frame/line interrupt requests, all advancing on the pixel clock enable.
module xs_video_timing_gen #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 288,
  parameter int HS_END   = 320,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 240,
  parameter int VS_START = 248,
  parameter int VS_END   = 251,
  parameter int DLY      = 2,
  parameter int HW       = 9,
  parameter int VW       = 9
) (
  input  logic          clk,
  input  logic          RSTn,
  input  logic          cen,
  input  logic          flip,
  input  logic [VW-1:0] irq_line,
  input  logic          vbl_ack,
  input  logic          line_ack,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic [HW-1:0] hpos,
  output logic [VW-1:0] vpos,
  output logic [HW-1:0] hpos_d,
  output logic          hblank,
  output logic          vblank,
  output logic          blank_n,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          csync_n,
  output logic          vbl_irq,
  output logic          line_irq,
  output logic          frame_tick,
  output logic          flip_q
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S   = HW'(HS_START);
  localparam logic [HW-1:0] HS_E   = HW'(HS_END);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_S   = VW'(VS_START);
  localparam logic [VW-1:0] VS_E   = VW'(VS_END);

  logic          h_wrap;
  logic          frame_wrap;
  logic [HW-1:0] h_nx;
  logic [VW-1:0] v_nx;
  logic          flip_nx;
  logic          hblank_nx;
  logic          vblank_nx;
  logic          hs_nx;
  logic          vs_nx;
  logic [HW-1:0] hpos_nx;
  logic [VW-1:0] vpos_nx;
  logic          vbl_set;
  logic          line_set;

  // Every registered output is derived from the next counter values so that
  // outputs and counters update on the same edge.
  always_comb begin
    h_wrap     = (hcnt == H_LAST);
    h_nx       = h_wrap ? '0 : hcnt + 1'b1;
    v_nx       = vcnt;
    if (h_wrap) v_nx = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    frame_wrap = cen && h_wrap && (vcnt == V_LAST);
    flip_nx    = frame_wrap ? flip : flip_q;
    hblank_nx  = (h_nx >= H_ACT);
    vblank_nx  = (v_nx >= V_ACT);
    hs_nx      = (h_nx >= HS_S) && (h_nx < HS_E);
    vs_nx      = (v_nx >= VS_S) && (v_nx < VS_E);
    hpos_nx    = (flip_nx && !hblank_nx) ? (H_ACT - HW'(1) - h_nx) : h_nx;
    vpos_nx    = (flip_nx && !vblank_nx) ? (V_ACT - VW'(1) - v_nx) : v_nx;
    vbl_set    = cen && h_wrap && (v_nx == V_ACT);
    // h_nx == H_ACT never coincides with a line wrap, so vcnt is the current line.
    line_set   = cen && (h_nx == H_ACT) && (vcnt == irq_line);
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      hcnt    <= '0;
      vcnt    <= '0;
      hpos    <= '0;
      vpos    <= '0;
      flip_q  <= 1'b0;
      hblank  <= 1'b0;
      vblank  <= 1'b0;
      blank_n <= 1'b1;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      csync_n <= 1'b1;
    end else if (cen) begin
      hcnt    <= h_nx;
      vcnt    <= v_nx;
      hpos    <= hpos_nx;
      vpos    <= vpos_nx;
      flip_q  <= flip_nx;
      hblank  <= hblank_nx;
      vblank  <= vblank_nx;
      blank_n <= ~(hblank_nx | vblank_nx);
      hsync_n <= ~hs_nx;
      vsync_n <= ~vs_nx;
      csync_n <= ~(hs_nx ^ vs_nx);
    end
  end

  // Interrupt flags and frame_tick run on every clk; a set beats a same-edge ack.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      vbl_irq    <= 1'b0;
      line_irq   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (vbl_set)       vbl_irq <= 1'b1;
      else if (vbl_ack)  vbl_irq <= 1'b0;
      if (line_set)      line_irq <= 1'b1;
      else if (line_ack) line_irq <= 1'b0;
    end
  end

  generate
    if (DLY == 0) begin : g_no_dly
      assign hpos_d = hpos;
    end else begin : g_dly
      logic [HW-1:0] dly_q [DLY];
      always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
          for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
        end else if (cen) begin
          dly_q[0] <= hpos;
          for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign hpos_d = dly_q[DLY-1];
    end
  endgenerate

endmodule
